// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory controller.
// Holds the RV32I load/store funct3 codes, the FSM state type and the latched request record.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic [6:0] imm_11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_4_0;
    logic [6:0] opcode;
  } S_Type;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension
// and the misaligned/illegal access check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    rdata_o = '0;
    unique case (funct3_i)
      OP_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      OP_LW:   rdata_o = shifted;
      OP_LBU:  rdata_o = {24'b0, shifted[7:0]};
      OP_LHU:  rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end

  always_comb begin
    if (store_i) illegal = (funct3_i > OP_SW);
    else         illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    err_o = illegal || misaligned;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store bus sequencer: accepts one core access, runs req/gnt/rvalid with a timeout,
// and returns a single-cycle response while holding busy to stall the core.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  lsu_req_t    req_q, req_d, req_in, req_cur;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_err;
  logic        timed_out;

  // One aligner serves both the incoming request (error check at accept) and the latched one.
  always_comb begin
    req_in  = '{store: req_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    req_cur = (state_q == S_IDLE) ? req_in : req_q;
  end

  lsu_align u_align (
    .store_i   (req_cur.store),
    .funct3_i  (req_cur.funct3),
    .addr_lo_i (req_cur.addr[1:0]),
    .wdata_i   (req_cur.wdata),
    .rdata_i   (mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .err_o     (al_err)
  );

  assign timed_out = (cnt_q >= TO_LAST);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          cnt_d = '0;
          if (al_err) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_ISSUE;
            err_d   = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          if (req_q.store) begin
            state_d = S_RESP;
            rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = al_rdata;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them without waiting for a clock.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && err_q;
    rsp_rdata = rdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == S_ISSUE) begin
      mem_req   = 1'b1;
      mem_we    = req_q.store;
      mem_addr  = {req_q.addr[31:2], 2'b00};
      mem_be    = al_be;
      mem_wdata = req_q.store ? al_wdata : '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a default-timeout instance plus a TIMEOUT_CYCLES=4 instance
// sharing the same stimulus; inputs change and outputs are sampled on the falling edge.
module tb_lsu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, rsp_valid, rsp_err, busy, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        t_req_ready, t_rsp_valid, t_rsp_err, t_busy, t_mem_req, t_mem_we;
  logic [31:0] t_rsp_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_be;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(t_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err), .busy(t_busy),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
    .mem_wdata(t_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    total++;
    if ({req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100000", {req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err});
    end
    total++;
    if ({mem_be, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_data be=%h addr=%h wdata=%h rdata=%h exp all 0", mem_be, mem_addr, mem_wdata, rsp_rdata);
    end
    @(negedge CLK); reset = 1'b1;
    @(negedge CLK);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release ready=%b busy=%b exp 1/0", req_ready, busy);
    end
  endtask

  task automatic test_store_word;
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    @(negedge CLK); req_valid = 1'b0;
    total++;
    if ({mem_req, mem_we, busy, rsp_valid} !== 4'b1110 || mem_be !== 4'b1111) begin
      bad++; $display("FAIL sw_issue req/we/busy/rsp=%b be=%b exp 1110/1111", {mem_req, mem_we, busy, rsp_valid}, mem_be);
    end
    total++;
    if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_bus addr=%h wdata=%h exp 00000100/deadbeef", mem_addr, mem_wdata);
    end
    mem_gnt = 1'b1;
    @(negedge CLK); mem_gnt = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, mem_req, req_ready} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL sw_rsp valid/err/req/ready=%b rdata=%h exp 1000/0", {rsp_valid, rsp_err, mem_req, req_ready}, rsp_rdata);
    end
    @(negedge CLK);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL sw_idle valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_store_byte;
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h103; req_wdata = 32'h000000A5;
    @(negedge CLK); req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h100 || mem_wdata !== 32'hA5A5A5A5) begin
        bad++; $display("FAIL sb_bus cyc=%0d req=%b we=%b be=%b addr=%h wdata=%h exp 1/1/1000/00000100/a5a5a5a5",
                        i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      if (i == 1) mem_gnt = 1'b1;
      @(negedge CLK);
    end
    mem_gnt = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL sb_rsp valid=%b err=%b exp 1/0", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [3:0] exp_be, input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = 32'h55555555;
    @(negedge CLK); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== exp_be || mem_addr !== {addr[31:2], 2'b00} || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL %s_issue cyc=%0d req=%b we=%b be=%b addr=%h rsp=%b exp 1/0/%b/%h/0",
                        nm, i, mem_req, mem_we, mem_be, mem_addr, rsp_valid, exp_be, {addr[31:2], 2'b00});
      end
      mem_rvalid = (i == 0);
      mem_rdata  = 32'hBAD0BAD0;
      mem_gnt    = (i == 3);
      @(negedge CLK);
    end
    mem_gnt = 1'b0;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL %s_wait req=%b busy=%b rsp=%b exp 0/1/0", nm, mem_req, busy, rsp_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge CLK); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp) begin
      bad++; $display("FAIL %s_rsp valid=%b err=%b rdata=%h exp 1/0/%h", nm, rsp_valid, rsp_err, rsp_rdata, exp);
    end
    @(negedge CLK);
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp) begin
      bad++; $display("FAIL %s_hold valid=%b rdata=%h exp 0/%h", nm, rsp_valid, rsp_rdata, exp);
    end
  endtask

  task automatic test_error(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge CLK);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = 32'hFFFFFFFF;
    @(negedge CLK); req_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, mem_req, req_ready} !== 4'b1100 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL %s valid/err/req/ready=%b rdata=%h exp 1100/0", nm, {rsp_valid, rsp_err, mem_req, req_ready}, rsp_rdata);
    end
    @(negedge CLK);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL %s_after valid=%b ready=%b req=%b exp 0/1/0", nm, rsp_valid, req_ready, mem_req);
    end
  endtask

  task automatic test_timeout;
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1;
    @(negedge CLK); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (t_mem_req !== 1'b1 || t_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL to_issue cyc=%0d req=%b rsp=%b exp 1/0", i, t_mem_req, t_rsp_valid);
      end
      @(negedge CLK);
    end
    total++;
    if ({t_rsp_valid, t_rsp_err, t_mem_req} !== 3'b110 || t_rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL to_abort valid/err/req=%b rdata=%h exp 110/0", {t_rsp_valid, t_rsp_err, t_mem_req}, t_rsp_rdata);
    end
    @(negedge CLK);
    total++;
    if (t_rsp_valid !== 1'b0 || t_busy !== 1'b0 || t_req_ready !== 1'b1 || mem_req !== 1'b1) begin
      bad++; $display("FAIL to_idle valid=%b busy=%b ready=%b long_req=%b exp 0/0/1/1", t_rsp_valid, t_busy, t_req_ready, mem_req);
    end
    mem_gnt = 1'b1;
    @(negedge CLK); mem_gnt = 1'b0;
    total++;
    if (t_rsp_valid !== 1'b0 || t_busy !== 1'b0 || t_mem_req !== 1'b0) begin
      bad++; $display("FAIL to_late_gnt valid=%b busy=%b req=%b exp 0/0/0", t_rsp_valid, t_busy, t_mem_req);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL long_wait_rsp valid=%b err=%b exp 1/0", rsp_valid, rsp_err);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h0;
    @(negedge CLK); req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_issue req=%b busy=%b ready=%b exp 0/0/1", mem_req, busy, req_ready);
    end
    @(negedge CLK); reset = 1'b1;
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h204;
    @(negedge CLK); req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge CLK); mem_gnt = 1'b0;
    total++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_wait_pre busy=%b req=%b exp 1/0", busy, mem_req);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_wait busy=%b req=%b rsp=%b exp 0/0/0", busy, mem_req, rsp_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge CLK); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); mem_rvalid = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL rst_no_rsp cyc=%0d valid=%b ready=%b exp 0/1", i, rsp_valid, req_ready);
      end
    end
    test_store_word();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load("lb",  3'b000, 32'h102, 4'b0100, 32'h12803456, 32'hFFFFFF80);
    test_load("lbu", 3'b100, 32'h102, 4'b0100, 32'h12803456, 32'h00000080);
    test_load("lhu", 3'b101, 32'h102, 4'b1100, 32'h12803456, 32'h00001280);
    test_load("lh",  3'b001, 32'h100, 4'b0011, 32'h00008001, 32'hFFFF8001);
    test_load("lw",  3'b010, 32'h104, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D);
    test_error("lw_misal",  1'b0, 3'b010, 32'h101);
    test_error("ld_f3_011", 1'b0, 3'b011, 32'h100);
    test_error("sh_misal",  1'b1, 3'b001, 32'h103);
    test_error("st_f3_100", 1'b1, 3'b100, 32'h100);
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Sequencer between the single-cycle core's load/store path and the data-memory bus. It takes one access request per instruction: the effective address from the LSU address stage, the store data and funct3. It then runs the req/gnt/rvalid bus handshake, generates byte enables and lane-replicated write data, and extracts and extends load data. It also flags misaligned or illegal accesses and bus timeouts, and holds busy so the core stalls until the response.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in ISSUE+WAIT before aborting with error (8-bit counter; legal range 1..255)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core presents an access
req_ready  out  1  controller accepts (only in IDLE)
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address from LSU
req_wdata  in  32  rs2 store data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores/errors
rsp_err  out  1  misaligned, illegal funct3 or timeout; valid with rsp_valid
busy  out  1  state != IDLE (core stall)
mem_req  out  1  bus request
mem_we  out  1  write strobe
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  bus accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset (reset=0, async): state=IDLE, timeout counter=0, latched request cleared. Outputs: mem_req/mem_we/rsp_valid/rsp_err/busy=0, mem_be=0, rsp_rdata=0, mem_addr/mem_wdata=0, req_ready=1.
- Reset mid-transaction: abandon immediately; mem_req drops asynchronously; no rsp_valid is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, latch store, funct3, addr and wdata.
  - If the access is illegal or misaligned, go to RESP with err=1 and raise no bus request.
  - Otherwise go to ISSUE and clear the counter.
- Illegal: load funct3 in {011,110,111}; store funct3 > 010.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- ISSUE: mem_req=1; mem_we/mem_addr/mem_be/mem_wdata held stable until mem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid seen in ISSUE is ignored.
- WAIT: mem_req=0. On mem_rvalid, capture the extended data and go to RESP.
- Timeout: the counter increments every cycle in ISSUE or WAIT. When it reaches TIMEOUT_CYCLES without the exiting event, go to RESP with err=1 and mem_req=0 next cycle. A late rvalid/gnt after the abort is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP.
- Latency with zero wait states:
  - Accept at cycle N; mem_req at N+1.
  - Store: gnt at N+1 gives rsp_valid at N+2.
  - Load: rvalid at N+2 gives rsp_valid at N+3.
  - Error detected at accept gives rsp_valid at N+1.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: same enables by size; mem_we=0.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load data: shift mem_rdata right by 8*addr[1:0].
  - LB: sign-extend bit7; LBU: zero-extend.
  - LH: sign-extend bit15; LHU: zero-extend.
  - LW: unchanged.
- rsp_rdata holds its value until the next RESP; it is 0 for stores and errors.
- Bus outputs are 0 outside ISSUE.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants OP_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum lsu_state_t.
  - Packed request struct (store, funct3, addr, wdata).
  - Existing S_Type.
- Sub-module lsu_align (combinational) computes be, replicated wdata, load extraction/extension, and misalign/illegal flags. The FSM and timeout counter stay in lsu_mem_ctrl.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in first ISSUE cycle -> mem_be=1111, mem_addr=0x100, mem_we=1; rsp_valid at N+2, err=0.
- SB addr=0x103, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102, mem_rdata=0x12803456 after 3 gnt-wait cycles -> rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x00001280.
- LW addr=0x101 -> no mem_req, rsp_valid at N+1, rsp_err=1, rsp_rdata=0. Load funct3=011 -> same.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req high 4 cycles then low; rsp_valid with err=1; a late gnt is ignored and the FSM returns to IDLE.
- reset asserted in WAIT -> mem_req/busy=0 immediately, no rsp_valid. After release, req_ready=1 and the next SW completes normally.
